restoring_divider: RTL and testbench
====================================

Name: restoring_divider

Overview:
- Sequential unsigned restoring divider with an internal FSM and datapath. It is the inverse-arithmetic counterpart of the team's Booth shift-add multiplier.
- Produces a quotient and remainder by iterative shift-subtract-restore, one quotient bit per cycle.
- Sits beside the multiplier in the arithmetic unit and uses the same start/done handshake: the caller pulses start, then waits for done.

Parameters:
- WIDTH, 16, operand/result width in bits (legal range 2..32)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  unsigned dividend; captured on the accepting edge
- divisor  input  WIDTH  unsigned divisor; captured on the accepting edge
- busy  output  1  high in LOAD and ITER
- done  output  1  one-cycle pulse, high while in DONE
- quotient  output  WIDTH  result; held until the next LOAD
- remainder  output  WIDTH  result; held until the next LOAD
- div_by_zero  output  1  error flag; valid with done, held with the results

Behaviour:
- Interface: one clock domain, clk; reset rst is synchronous and active-high.
- Reset (rst=1 at any edge, including mid-operation):
  - state returns to IDLE
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0
  - internal A, Q, M and count cleared
  - rst has priority over start
- Internal registers:
  - A: WIDTH+1 bits, partial remainder, with a sign bit
  - Q: WIDTH bits, dividend shifting out and quotient shifting in
  - M: WIDTH bits, divisor
  - count: $clog2(WIDTH)+1 bits
- FSM states: IDLE, LOAD, ITER, DONE.
- IDLE:
  - If start=1: capture dividend into Q and divisor into M, set A=0, go to LOAD.
  - Otherwise stay in IDLE.
- LOAD:
  - If M==0: go to DONE and set quotient={WIDTH{1}}, remainder=Q (the dividend), div_by_zero=1.
  - Otherwise: count=WIDTH, div_by_zero=0, go to ITER.
- ITER (one iteration per cycle):
  - Shift {A,Q} left by 1 and compute T = A_shifted - {1'b0,M}.
  - If T[WIDTH]==0: A=T, Q[0]=1.
  - Else: keep A_shifted (restore), Q[0]=0.
  - Decrement count.
  - When count reaches 0 on this edge: quotient=Q_new, remainder=A_new[WIDTH-1:0], go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- Latency:
  - Count the start-accepting edge as edge 1.
  - done is high in the cycle after edge WIDTH+2 (edge 18 for WIDTH=16).
  - Divide-by-zero: done is high in the cycle after edge 2.
  - Back-to-back throughput: one operation per WIDTH+3 cycles.
- Handshake rules:
  - start is ignored in LOAD, ITER and DONE; a start coinciding with the done cycle is dropped.
  - dividend and divisor may change freely after the accepting edge.
  - Results and div_by_zero remain stable from DONE until the edge that leaves the next LOAD.
- Arithmetic:
  - Purely unsigned.
  - quotient*divisor + remainder == dividend, with remainder < divisor, whenever divisor != 0.
  - Subtraction is done at WIDTH+1 bits; no overflow is possible.
- Boundary conditions:
  - dividend < divisor: quotient=0, remainder=dividend.
  - dividend=0: quotient=0, remainder=0, div_by_zero=0.
  - divisor=1: quotient=dividend, remainder=0.
- No X propagation: every output is driven from registers at all times.

Test Plan:
- Basic division, WIDTH=16: dividend=100, divisor=7, start for 1 cycle -> quotient=14, remainder=2, div_by_zero=0; done high for exactly 1 cycle after edge 18; busy high for edges 2..17 window.
- Maximum values: dividend=0xFFFF, divisor=1 -> quotient=0xFFFF, remainder=0. Then dividend=0xFFFF, divisor=0xFFFF -> quotient=1, remainder=0.
- Divide by zero and recovery: dividend=0x1234, divisor=0 -> done after edge 2, div_by_zero=1, quotient=0xFFFF, remainder=0x1234. A following 9/4 -> quotient=2, remainder=1, div_by_zero=0.
- Small dividend and handshake: dividend=5, divisor=9 -> quotient=0, remainder=5. Re-pulsing start during ITER and during the done cycle changes neither results nor timing, and the FSM returns to IDLE with no second done.
- Reset mid-operation: assert rst at edge 8 of 1000/3 -> next cycle all outputs 0 and state IDLE. A new 1000/3 then yields quotient=333, remainder=1 with normal latency.
- Randomized self-check: 1000 random unsigned pairs with divisor != 0 -> every result satisfies q*d+r==n and r<d; done count equals start-accept count.

Source files
------------

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per cycle using shift-subtract-restore.
// Uses the arithmetic unit's start/done handshake. The current state is visible on state_dbg.
module restoring_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled only in IDLE. The edge that samples it high captures
  // dividend/divisor. done is high for exactly one cycle. Results stay valid from done
  // until the next operation leaves LOAD.

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    count;

  logic [WIDTH+1:0] a_shift;
  logic [WIDTH+1:0] t;
  logic [WIDTH:0]   a_iter;
  logic [WIDTH-1:0] q_iter;
  logic [CW-1:0]    count_dec;
  logic             borrow;

  // a is kept below m, so a_shift < 2*m and the subtraction cannot overflow.
  // The extra top bit carries the borrow out of the (WIDTH+1)-bit difference.
  always_comb begin
    a_shift   = {a, q[WIDTH-1]};
    t         = a_shift - {2'b00, m};
    borrow    = t[WIDTH+1];
    a_iter    = borrow ? a_shift[WIDTH:0] : t[WIDTH:0];
    q_iter    = {q[WIDTH-2:0], ~borrow};
    count_dec = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = LOAD;
      LOAD: state_next = (m == '0) ? DONE : ITER;
      ITER: if (count_dec == '0) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a           <= '0;
      q           <= '0;
      m           <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      busy <= (state_next == LOAD) || (state_next == ITER);
      done <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            q <= dividend;
            m <= divisor;
            a <= '0;
          end
        end
        LOAD: begin
          if (m == '0) begin
            quotient    <= '1;
            remainder   <= q;
            div_by_zero <= 1'b1;
          end else begin
            count       <= CNT_INIT;
            div_by_zero <= 1'b0;
          end
        end
        ITER: begin
          a     <= a_iter;
          q     <= q_iter;
          count <= count_dec;
          if (count_dec == '0) begin
            quotient  <= q_iter;
            remainder <= a_iter[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed and random self-checking bench for restoring_divider (WIDTH=16).
module tb_restoring_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic [1:0]  state_dbg;

  int n_asserts = 0;
  int n_fail    = 0;
  int n_accept  = 0;
  int done_cnt  = 0;

  restoring_divider #(.WIDTH(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .state_dbg   (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: pulse start for one edge (edge 1), then wait for done, counting edges.
  // Returns at the negedge where done is first seen, so lat is that edge number.
  task automatic do_op(input logic [15:0] n, input logic [15:0] d, input bit repulse,
                       output int lat, output bit all_busy);
    @(negedge clk);
    dividend = n;
    divisor  = d;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
    n_accept++;
    lat      = 1;
    all_busy = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) all_busy = 1'b0;
      @(negedge clk);
      lat++;
      if (repulse && lat == 5) start = 1'b1;
      else if (repulse && lat == 6) start = 1'b0;
    end
    if (repulse) start = 1'b1;
  endtask

  task automatic finish_op(input string tag, input logic [15:0] eq, input logic [15:0] er,
                           input logic ez, input int elat, input int lat, input bit all_busy);
    check({tag, "_latency"}, lat, elat);
    check({tag, "_busy_window"}, {31'd0, all_busy}, 32'd1);
    check({tag, "_quotient"}, {16'd0, quotient}, {16'd0, eq});
    check({tag, "_remainder"}, {16'd0, remainder}, {16'd0, er});
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    check({tag, "_back_idle"}, {30'd0, state_dbg}, 32'd0);
    check({tag, "_quotient_held"}, {16'd0, quotient}, {16'd0, eq});
  endtask

  initial begin
    int lat;
    bit all_busy;
    int extra;
    int base_done;
    logic [15:0] n, d;

    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_quotient", {16'd0, quotient}, 32'd0);
    check("reset_remainder", {16'd0, remainder}, 32'd0);
    check("reset_dbz", {31'd0, div_by_zero}, 32'd0);
    check("reset_state", {30'd0, state_dbg}, 32'd0);
    rst = 1'b0;

    do_op(16'd100, 16'd7, 1'b0, lat, all_busy);
    finish_op("div_100_7", 16'd14, 16'd2, 1'b0, 18, lat, all_busy);

    do_op(16'hFFFF, 16'd1, 1'b0, lat, all_busy);
    finish_op("div_max_1", 16'hFFFF, 16'd0, 1'b0, 18, lat, all_busy);

    do_op(16'hFFFF, 16'hFFFF, 1'b0, lat, all_busy);
    finish_op("div_max_max", 16'd1, 16'd0, 1'b0, 18, lat, all_busy);

    do_op(16'h1234, 16'd0, 1'b0, lat, all_busy);
    finish_op("div_by_zero", 16'hFFFF, 16'h1234, 1'b1, 2, lat, all_busy);

    do_op(16'd9, 16'd4, 1'b0, lat, all_busy);
    finish_op("recover_9_4", 16'd2, 16'd1, 1'b0, 18, lat, all_busy);

    do_op(16'd0, 16'd5, 1'b0, lat, all_busy);
    finish_op("zero_dividend", 16'd0, 16'd0, 1'b0, 18, lat, all_busy);

    // Extra start pulses in ITER and in the done cycle must be dropped.
    do_op(16'd5, 16'd9, 1'b1, lat, all_busy);
    finish_op("small_repulse", 16'd0, 16'd5, 1'b0, 18, lat, all_busy);
    extra = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("repulse_no_second_done", extra, 0);
    check("repulse_idle", {30'd0, state_dbg}, 32'd0);

    // Reset asserted at edge 8 of 1000/3.
    @(negedge clk);
    dividend = 16'd1000;
    divisor  = 16'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_quotient", {16'd0, quotient}, 32'd0);
    check("midrst_remainder", {16'd0, remainder}, 32'd0);
    check("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("midrst_state", {30'd0, state_dbg}, 32'd0);
    rst = 1'b0;

    do_op(16'd1000, 16'd3, 1'b0, lat, all_busy);
    finish_op("after_rst_1000_3", 16'd333, 16'd1, 1'b0, 18, lat, all_busy);

    // Random pairs checked against the division identity.
    base_done = done_cnt;
    for (int i = 0; i < 1000; i++) begin
      n = 16'($urandom_range(0, 16'hFFFF));
      if ($urandom_range(0, 3) == 0) d = 16'($urandom_range(1, 15));
      else d = 16'($urandom_range(1, 16'hFFFF));
      do_op(n, d, 1'b0, lat, all_busy);
      check("rand_latency", lat, 18);
      check("rand_identity", 32'(quotient) * 32'(d) + 32'(remainder), {16'd0, n});
      check("rand_rem_lt_div", {31'd0, remainder < d}, 32'd1);
      check("rand_dbz", {31'd0, div_by_zero}, 32'd0);
    end
    @(negedge clk);
    check("rand_done_count", done_cnt - base_done, 1000);
    check("total_done_vs_accept", done_cnt, n_accept);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
